// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin SPI host sharing with chip-select gap and hold timeout
module spi_bus_arbiter #(
  parameter int NumReq = 2,
  parameter int GapCycles = 4,
  parameter int TimeoutCycles = 65535,
  localparam int Ow = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  input  logic [NumReq-1:0] done_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [NumReq-1:0] cs_no,
  output logic [Ow-1:0]     owner_o,
  output logic              busy_o,
  output logic              timeout_o,
  output logic [Ow-1:0]     timeout_id_o
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;
  state_e state;
  logic [Ow-1:0] ptr, win;
  logic [15:0] hold_cnt;
  logic [3:0] gap_cnt;
  logic rel, expire;
  function automatic logic [Ow-1:0] pick(input logic [NumReq-1:0] r, input logic [Ow-1:0] p);
    logic [NumReq-1:0] rr;
    int i;
    pick = p;
    for (int k = NumReq - 1; k >= 0; k--) begin
      i = (int'(p) + k) % NumReq;
      rr = r >> i;
      if (rr[0]) pick = Ow'(i);
    end
  endfunction
  always_comb begin
    win = pick(req_i, ptr);
    rel = done_i[owner_o] | ~req_i[owner_o];
    expire = (TimeoutCycles != 0) && (hold_cnt == 16'(TimeoutCycles - 1));
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      gnt_o <= '0;
      cs_no <= '1;
      owner_o <= '0;
      busy_o <= 1'b0;
      timeout_o <= 1'b0;
      timeout_id_o <= '0;
      ptr <= '0;
      hold_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        IDLE: if (|req_i) begin
          state <= GRANT;
          gnt_o <= NumReq'(1) << win;
          cs_no <= ~(NumReq'(1) << win);
          owner_o <= win;
          busy_o <= 1'b1;
          ptr <= Ow'((int'(win) + 1) % NumReq);
          hold_cnt <= '0;
        end
        GRANT: if (rel || expire) begin
          state <= (GapCycles == 0) ? IDLE : GAP;
          gnt_o <= '0;
          cs_no <= '1;
          owner_o <= '0;
          busy_o <= (GapCycles != 0);
          gap_cnt <= '0;
          // a release in the expiry cycle wins over the timeout
          timeout_o <= ~rel;
          if (!rel) timeout_id_o <= owner_o;
        end else hold_cnt <= hold_cnt + 16'd1;
        GAP: if (gap_cnt == 4'(GapCycles - 1)) begin
          state <= IDLE;
          busy_o <= 1'b0;
        end else gap_cnt <= gap_cnt + 4'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: randomized and directed checks of spi_bus_arbiter against a behavioural model
module tb_spi_bus_arbiter;
  logic clk_i = 1'b0;
  logic rst_i;
  logic [1:0] req_a, done_a, gnt_a, cs_a;
  logic [0:0] own_a, tid_a;
  logic busy_a, to_a;
  logic [2:0] req_b, done_b, gnt_b, cs_b;
  logic [1:0] own_b, tid_b;
  logic busy_b, to_b;
  int total = 0;
  int bad = 0;

  always #5 clk_i = ~clk_i;

  spi_bus_arbiter #(.NumReq(2), .GapCycles(4), .TimeoutCycles(8)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_a), .done_i(done_a), .gnt_o(gnt_a),
    .cs_no(cs_a), .owner_o(own_a), .busy_o(busy_a), .timeout_o(to_a), .timeout_id_o(tid_a));
  spi_bus_arbiter #(.NumReq(3), .GapCycles(0), .TimeoutCycles(5)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_b), .done_i(done_b), .gnt_o(gnt_b),
    .cs_no(cs_b), .owner_o(own_b), .busy_o(busy_b), .timeout_o(to_b), .timeout_id_o(tid_b));

  typedef struct {
    int owner;
    int held;
    int gap_left;
    int ptr;
    bit to;
    int to_id;
  } mdl_t;

  localparam mdl_t MRST = '{owner: -1, held: 0, gap_left: 0, ptr: 0, to: 1'b0, to_id: 0};
  mdl_t ma = MRST;
  mdl_t mb = MRST;

  function automatic mdl_t mstep(mdl_t s, logic [3:0] req, logic [3:0] done, int n, int g, int t);
    mdl_t x = s;
    bit rel;
    x.to = 1'b0;
    if (s.owner >= 0) begin
      rel = done[s.owner] || !req[s.owner];
      x.held = s.held + 1;
      if (rel || (t != 0 && x.held == t)) begin
        x.owner = -1;
        x.gap_left = g;
        if (!rel) begin
          x.to = 1'b1;
          x.to_id = s.owner;
        end
      end
    end else if (s.gap_left > 0) begin
      x.gap_left = s.gap_left - 1;
    end else begin
      for (int k = 0; k < n; k++) begin
        if (x.owner < 0 && req[(s.ptr + k) % n]) begin
          x.owner = (s.ptr + k) % n;
          x.held = 0;
          x.ptr = (x.owner + 1) % n;
        end
      end
    end
    return x;
  endfunction

  function automatic int gnt_of(mdl_t s);
    return (s.owner >= 0) ? (1 << s.owner) : 0;
  endfunction

  function automatic int busy_of(mdl_t s);
    return (s.owner >= 0 || s.gap_left > 0) ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ma <= MRST;
      mb <= MRST;
    end else begin
      ma <= mstep(ma, {2'b0, req_a}, {2'b0, done_a}, 2, 4, 8);
      mb <= mstep(mb, {1'b0, req_b}, {1'b0, done_b}, 3, 0, 5);
    end
  end

  always @(negedge clk_i) begin
    chk("a_gnt", int'(gnt_a), gnt_of(ma));
    chk("a_cs", int'(cs_a), int'(~gnt_of(ma)) & 3);
    chk("a_owner", int'(own_a), (ma.owner >= 0) ? ma.owner : 0);
    chk("a_busy", int'(busy_a), busy_of(ma));
    chk("a_to", int'(to_a), int'(ma.to));
    chk("a_to_id", int'(tid_a), ma.to_id);
    chk("b_gnt", int'(gnt_b), gnt_of(mb));
    chk("b_cs", int'(cs_b), int'(~gnt_of(mb)) & 7);
    chk("b_owner", int'(own_b), (mb.owner >= 0) ? mb.owner : 0);
    chk("b_busy", int'(busy_b), busy_of(mb));
    chk("b_to", int'(to_b), int'(mb.to));
    chk("b_to_id", int'(tid_b), mb.to_id);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  initial begin
    rst_i = 1'b1;
    req_a = '0;
    done_a = '0;
    req_b = '0;
    done_b = '0;
    tick(2);
    rst_i = 1'b0;
    chk("rst_gnt", int'(gnt_a), 0);
    chk("rst_cs", int'(cs_a), 3);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_to_id", int'(tid_a), 0);
    req_a = 2'b11;
    tick();
    chk("c1_gnt", int'(gnt_a), 1);
    chk("c1_cs", int'(cs_a), 2);
    chk("c1_owner", int'(own_a), 0);
    tick();
    done_a = 2'b10;
    tick();
    done_a = 2'b00;
    chk("c3_nonowner_gnt", int'(gnt_a), 1);
    chk("c3_nonowner_own", int'(own_a), 0);
    tick(2);
    done_a = 2'b01;
    tick();
    done_a = 2'b00;
    chk("c6_gnt", int'(gnt_a), 0);
    chk("c6_cs", int'(cs_a), 3);
    chk("c6_busy", int'(busy_a), 1);
    tick(4);
    chk("c10_gnt", int'(gnt_a), 0);
    chk("c10_busy", int'(busy_a), 0);
    tick();
    chk("c11_gnt", int'(gnt_a), 2);
    chk("c11_owner", int'(own_a), 1);
    tick(7);
    chk("c18_gnt", int'(gnt_a), 2);
    chk("c18_to", int'(to_a), 0);
    tick();
    chk("c19_gnt", int'(gnt_a), 0);
    chk("c19_to", int'(to_a), 1);
    chk("c19_to_id", int'(tid_a), 1);
    tick();
    chk("c20_to", int'(to_a), 0);
    chk("c20_to_id", int'(tid_a), 1);
    tick(4);
    chk("c24_gnt", int'(gnt_a), 1);
    #1 rst_i = 1'b1;
    #1;
    chk("arst_gnt", int'(gnt_a), 0);
    chk("arst_cs", int'(cs_a), 3);
    chk("arst_to", int'(to_a), 0);
    chk("arst_owner", int'(own_a), 0);
    tick();
    rst_i = 1'b0;
    tick();
    chk("postrst_gnt", int'(gnt_a), 1);
    req_a = '0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    req_b = 3'b001;
    tick();
    chk("b_grant", int'(gnt_b), 1);
    tick();
    req_b = 3'b000;
    tick();
    chk("b_drop_gnt", int'(gnt_b), 0);
    chk("b_drop_busy", int'(busy_b), 0);
    req_b = 3'b001;
    tick();
    chk("b_regrant", int'(gnt_b), 1);
    req_b = '0;
    tick(2);
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 2; i++) if ($urandom_range(11) == 0) req_a[i] = ~req_a[i];
      for (int i = 0; i < 3; i++) if ($urandom_range(9) == 0) req_b[i] = ~req_b[i];
      for (int i = 0; i < 2; i++) done_a[i] = ($urandom_range(7) == 0);
      for (int i = 0; i < 3; i++) done_b[i] = ($urandom_range(7) == 0);
      rst_i = ($urandom_range(499) == 0);
      tick();
    end
    rst_i = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
